ni_packetizer: RTL

//  Network-interface transmit side: turns PE packet requests and payload words into header/body/tail flits
//  and drives a router input port (router RX, DRTS, CTS) via RTS/CTS. Sits between PE and router Local port.
//  One packet in flight; one flit per cycle while CTS stays high.

---
 rtl/ni_packetizer_pkg.sv | 38 +++
 rtl/ni_packetizer_if.sv | 28 ++
 rtl/ni_flit_reg.sv | 34 +++
 rtl/ni_packetizer.sv | 112 +++++++++++
 4 files changed

// File: rtl/ni_packetizer_pkg.sv
// Shared constants, flit type codes and helpers for the NI transmit packetizer.
// Flit layout: [31:29] type, [28:1] fields or payload, [0] even parity over [31:1].
package ni_packetizer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int AXIS       = 4;
    localparam int LEN_W      = 12;
    localparam int ID_W       = 8;
    localparam int PAYLOAD_W  = 28;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_TAIL = 2'd2
    } ni_state_t;

    // Header fields: length (payload+1), destination, source, packet id.
    function automatic logic [DATA_WIDTH-1:1] make_header(
        input logic [LEN_W-1:0] len_field,
        input logic [AXIS-1:0]  dst,
        input logic [AXIS-1:0]  src,
        input logic [ID_W-1:0]  id
    );
        return {FLIT_HEADER, len_field, dst, src, id};
    endfunction

    function automatic logic [DATA_WIDTH-1:1] make_payload(
        input logic [2:0]           flit_type,
        input logic [PAYLOAD_W-1:0] data
    );
        return {flit_type, data};
    endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// PE request/payload streams plus router RTS/CTS port, bundled for the packetizer.
interface ni_packetizer_if;
    import ni_packetizer_pkg::*;

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [AXIS-1:0]       pkt_dst;
    logic [LEN_W-1:0]      pkt_len;
    logic                  word_valid;
    logic                  word_ready;
    logic [PAYLOAD_W-1:0]  word_data;
    logic [DATA_WIDTH-1:0] TX;
    logic                  RTS;
    logic                  CTS;
    logic                  pkt_sent;
    logic                  err_len;

    modport slave (
        input  pkt_valid, pkt_dst, pkt_len, word_valid, word_data, CTS,
        output pkt_ready, word_ready, TX, RTS, pkt_sent, err_len
    );

    modport master (
        output pkt_valid, pkt_dst, pkt_len, word_valid, word_data, CTS,
        input  pkt_ready, word_ready, TX, RTS, pkt_sent, err_len
    );

endinterface

// File: rtl/ni_flit_reg.sv
// One-entry output register toward the router: appends parity and runs the RTS/CTS accept.
// The slot is free when empty or when its flit is taken this cycle, so it can refill back-to-back.
module ni_flit_reg
    import ni_packetizer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:1] load_flit,
    input  logic                  cts,
    output logic [DATA_WIDTH-1:0] tx,
    output logic                  rts,
    output logic                  free,
    output logic                  accept
);

    assign accept = rts && cts;
    assign free   = !rts || cts;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx  <= '0;
            rts <= 1'b0;
        end else if (free) begin
            if (load) begin
                tx  <= {load_flit, ^load_flit};
                rts <= 1'b1;
            end else begin
                rts <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side: turns PE packet requests and payload words into header/body/tail flits.
//   state   | meaning
//   ST_IDLE | waiting for a request; header is loaded into the output reg on accept
//   ST_BODY | forwarding body words, remaining counts body words still to send
//   ST_TAIL | next payload word becomes the tail flit
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int MAX_PAYLOAD = 4094
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AXIS-1:0] cur_addr,
    ni_packetizer_if.slave  bus
);

    ni_state_t             state;
    logic [LEN_W-1:0]      remaining;
    logic [ID_W-1:0]       pkt_id;
    logic                  pkt_sent_q;
    logic                  err_len_q;

    logic                  or_free;
    logic                  or_accept;
    logic                  or_load;
    logic [DATA_WIDTH-1:1] or_flit;
    logic [DATA_WIDTH-1:0] tx_q;
    logic                  rts_q;

    logic                  pkt_ready_c;
    logic                  word_ready_c;
    logic                  pkt_acc;
    logic                  word_acc;
    logic                  len_ok;
    logic                  tail_acc;
    logic [ID_W-1:0]       next_id;

    always_comb begin
        pkt_ready_c  = !rst && (state == ST_IDLE) && or_free;
        word_ready_c = !rst && (state != ST_IDLE) && or_free;
        pkt_acc      = bus.pkt_valid && pkt_ready_c;
        word_acc     = bus.word_valid && word_ready_c;
        len_ok       = (bus.pkt_len != '0) && (bus.pkt_len <= LEN_W'(MAX_PAYLOAD));
        tail_acc     = or_accept && (tx_q[DATA_WIDTH-1 -: 3] == FLIT_TAIL);
        // A header loaded on the tail's accepting edge must already carry the bumped id.
        next_id      = pkt_id + ID_W'(tail_acc);
        or_load      = (pkt_acc && len_ok) || word_acc;
        if (state == ST_IDLE) begin
            or_flit = make_header(bus.pkt_len + LEN_W'(1), bus.pkt_dst, cur_addr, next_id);
        end else if (state == ST_TAIL) begin
            or_flit = make_payload(FLIT_TAIL, bus.word_data);
        end else begin
            or_flit = make_payload(FLIT_BODY, bus.word_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            pkt_id     <= '0;
            pkt_sent_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            pkt_sent_q <= tail_acc;
            err_len_q  <= pkt_acc && !len_ok;
            pkt_id     <= next_id;
            case (state)
                ST_IDLE: begin
                    if (pkt_acc && len_ok) begin
                        remaining <= bus.pkt_len - LEN_W'(1);
                        state     <= (bus.pkt_len > LEN_W'(1)) ? ST_BODY : ST_TAIL;
                    end
                end
                ST_BODY: begin
                    if (word_acc) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (word_acc) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ni_flit_reg u_flit_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (or_load),
        .load_flit (or_flit),
        .cts       (bus.CTS),
        .tx        (tx_q),
        .rts       (rts_q),
        .free      (or_free),
        .accept    (or_accept)
    );

    assign bus.TX         = tx_q;
    assign bus.RTS        = rts_q;
    assign bus.pkt_ready  = pkt_ready_c;
    assign bus.word_ready = word_ready_c;
    assign bus.pkt_sent   = pkt_sent_q;
    assign bus.err_len    = err_len_q;

endmodule
